// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy bit and ROB tag.
// Multi-port reads with commit bypass, in-order multi-commit, one dispatch port.
module regfile_tagged #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int ROB_W   = 4,
  parameter int N_RD    = 4,
  parameter int N_CM    = 2,
  localparam int REG_AW = $clog2(REG_NUM)
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic                     in_rdy,
  input  logic                     in_flush_enable,
  input  logic                     in_dp_enable,
  input  logic [REG_AW-1:0]        in_dp_rd,
  input  logic [ROB_W-1:0]         in_dp_reorder,
  input  logic [N_RD*REG_AW-1:0]   in_rd_addr,
  output logic [N_RD-1:0]          out_rd_busy,
  output logic [N_RD*DATA_W-1:0]   out_rd_data,
  output logic [N_RD*ROB_W-1:0]    out_rd_reorder,
  input  logic [N_CM-1:0]          in_cm_enable,
  input  logic [N_CM*REG_AW-1:0]   in_cm_rd,
  input  logic [N_CM*DATA_W-1:0]   in_cm_value,
  input  logic [N_CM*ROB_W-1:0]    in_cm_reorder,
  output logic [REG_AW:0]          out_busy_cnt
);

  logic [DATA_W-1:0]  data_q [REG_NUM];
  logic [DATA_W-1:0]  data_d [REG_NUM];
  logic [ROB_W-1:0]   tag_q  [REG_NUM];
  logic [ROB_W-1:0]   tag_d  [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic [REG_AW:0]    cnt_q;
  logic [REG_AW:0]    cnt_d;
  logic               byp_en;

  assign byp_en = in_rdy && !in_flush_enable;

  // Read ports: the youngest matching commit decides both data and busy clear
  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic [ROB_W-1:0]  tag;
    logic              hit_clr;

    assign addr = in_rd_addr[i*REG_AW +: REG_AW];

    always_comb begin
      data    = data_q[addr];
      busy    = busy_q[addr];
      tag     = tag_q[addr];
      hit_clr = 1'b0;
      for (int j = 0; j < N_CM; j++) begin
        if (byp_en && in_cm_enable[j] && (in_cm_rd[j*REG_AW +: REG_AW] == addr)) begin
          data    = in_cm_value[j*DATA_W +: DATA_W];
          hit_clr = busy_q[addr] && (tag_q[addr] == in_cm_reorder[j*ROB_W +: ROB_W]);
        end
      end
      if (hit_clr) begin
        busy = 1'b0;
        tag  = '0;
      end
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
        tag  = '0;
      end
    end

    assign out_rd_data[i*DATA_W +: DATA_W]  = data;
    assign out_rd_busy[i]                   = busy;
    assign out_rd_reorder[i*ROB_W +: ROB_W] = tag;
  end

  // Ascending port order lets the youngest commit win same-register writes
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (in_rdy) begin
      for (int j = 0; j < N_CM; j++) begin
        if (in_cm_enable[j] && (in_cm_rd[j*REG_AW +: REG_AW] != '0)) begin
          data_d[in_cm_rd[j*REG_AW +: REG_AW]] = in_cm_value[j*DATA_W +: DATA_W];
          if (!in_flush_enable &&
              (tag_q[in_cm_rd[j*REG_AW +: REG_AW]] == in_cm_reorder[j*ROB_W +: ROB_W])) begin
            busy_d[in_cm_rd[j*REG_AW +: REG_AW]] = 1'b0;
            tag_d[in_cm_rd[j*REG_AW +: REG_AW]]  = '0;
          end
        end
      end
      if (in_flush_enable) begin
        busy_d = '0;
        for (int r = 0; r < REG_NUM; r++) tag_d[r] = '0;
      end else if (in_dp_enable && (in_dp_rd != '0)) begin
        busy_d[in_dp_rd] = 1'b1;
        tag_d[in_dp_rd]  = in_dp_reorder;
      end
    end
    cnt_d = '0;
    for (int r = 0; r < REG_NUM; r++) cnt_d = cnt_d + {{REG_AW{1'b0}}, busy_d[r]};
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int r = 0; r < REG_NUM; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_tagged.sv
// Scoreboard bench for regfile_tagged: stimulus queues expectations,
// a negedge monitor pops and compares them against the read ports and busy count.
module tb_regfile_tagged;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int AW = 5;
  localparam int RW = 4;
  localparam int NR = 4;
  localparam int NC = 2;

  logic            in_clk = 1'b0;
  logic            in_rst_n;
  logic            in_rdy;
  logic            in_flush_enable;
  logic            in_dp_enable;
  logic [AW-1:0]   in_dp_rd;
  logic [RW-1:0]   in_dp_reorder;
  logic [NR*AW-1:0] in_rd_addr;
  logic [NR-1:0]   out_rd_busy;
  logic [NR*DW-1:0] out_rd_data;
  logic [NR*RW-1:0] out_rd_reorder;
  logic [NC-1:0]   in_cm_enable;
  logic [NC*AW-1:0] in_cm_rd;
  logic [NC*DW-1:0] in_cm_value;
  logic [NC*RW-1:0] in_cm_reorder;
  logic [AW:0]     out_busy_cnt;

  regfile_tagged #(.DATA_W(DW), .REG_NUM(RN), .ROB_W(RW), .N_RD(NR), .N_CM(NC)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_rdy(in_rdy),
    .in_flush_enable(in_flush_enable), .in_dp_enable(in_dp_enable),
    .in_dp_rd(in_dp_rd), .in_dp_reorder(in_dp_reorder), .in_rd_addr(in_rd_addr),
    .out_rd_busy(out_rd_busy), .out_rd_data(out_rd_data), .out_rd_reorder(out_rd_reorder),
    .in_cm_enable(in_cm_enable), .in_cm_rd(in_cm_rd), .in_cm_value(in_cm_value),
    .in_cm_reorder(in_cm_reorder), .out_busy_cnt(out_busy_cnt)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    int            kind;
    int            port;
    logic          busy;
    logic [DW-1:0] data;
    logic [RW-1:0] tag;
    logic [AW:0]   cnt;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  mon_e;
  string mon_nm;
  logic          g_busy;
  logic [DW-1:0] g_data;
  logic [RW-1:0] g_tag;

  task automatic exp_rd(input string nm, input int p, input logic b,
                        input logic [DW-1:0] d, input logic [RW-1:0] t);
    exp_t e;
    e.kind = 0; e.port = p; e.busy = b; e.data = d; e.tag = t; e.cnt = '0;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic exp_cnt(input string nm, input int c);
    exp_t e;
    e.kind = 1; e.port = 0; e.busy = 1'b0; e.data = '0; e.tag = '0; e.cnt = (AW+1)'(c);
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  always @(negedge in_clk) begin
    while (sb_q.size() > 0) begin
      mon_e  = sb_q.pop_front();
      mon_nm = nm_q.pop_front();
      checks++;
      if (mon_e.kind == 1) begin
        if (out_busy_cnt !== mon_e.cnt) begin
          errors++;
          $display("FAIL %s: busy_cnt got %0d want %0d", mon_nm, out_busy_cnt, mon_e.cnt);
        end
      end else begin
        g_busy = out_rd_busy[mon_e.port];
        g_data = out_rd_data[mon_e.port*DW +: DW];
        g_tag  = out_rd_reorder[mon_e.port*RW +: RW];
        if (g_busy !== mon_e.busy || g_data !== mon_e.data || g_tag !== mon_e.tag) begin
          errors++;
          $display("FAIL %s: port%0d busy/data/tag got %0b/%h/%h want %0b/%h/%h",
                   mon_nm, mon_e.port, g_busy, g_data, g_tag,
                   mon_e.busy, mon_e.data, mon_e.tag);
        end
      end
    end
  end

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle();
    in_rdy          = 1'b1;
    in_flush_enable = 1'b0;
    in_dp_enable    = 1'b0;
    in_cm_enable    = '0;
  endtask

  task automatic cm(input int j, input logic [AW-1:0] r, input logic [DW-1:0] v,
                    input logic [RW-1:0] t);
    in_cm_enable[j]          = 1'b1;
    in_cm_rd[j*AW +: AW]     = r;
    in_cm_value[j*DW +: DW]  = v;
    in_cm_reorder[j*RW +: RW] = t;
  endtask

  task automatic dp(input logic [AW-1:0] r, input logic [RW-1:0] t);
    in_dp_enable  = 1'b1;
    in_dp_rd      = r;
    in_dp_reorder = t;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    in_rd_addr[p*AW +: AW] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    in_rst_n = 1'b0;
    idle();
    in_dp_rd = '0; in_dp_reorder = '0; in_rd_addr = '0;
    in_cm_rd = '0; in_cm_value = '0; in_cm_reorder = '0;

    step(); rd(0, 5'd5);
    exp_rd("rst_init", 0, 1'b0, 32'h0, 4'h0); exp_cnt("rst_init_cnt", 0);
    step(); in_rst_n = 1'b1;

    // write x5 then reset asynchronously mid-cycle with a dispatch in flight
    step(); idle(); cm(0, 5'd5, 32'h1234, 4'd0); rd(0, 5'd5);
    exp_rd("wr_byp", 0, 1'b0, 32'h1234, 4'h0);
    step(); idle(); rd(1, 5'd5);
    exp_rd("wr_store", 1, 1'b0, 32'h1234, 4'h0);
    step(); idle(); dp(5'd5, 4'd3); in_rst_n = 1'b0; rd(0, 5'd5);
    exp_rd("rst_async", 0, 1'b0, 32'h0, 4'h0); exp_cnt("rst_cnt", 0);
    step(); in_rst_n = 1'b1; idle(); rd(0, 5'd5);
    exp_rd("rst_discard", 0, 1'b0, 32'h0, 4'h0); exp_cnt("rst_discard_cnt", 0);

    // dispatch then matching commit
    step(); idle(); dp(5'd5, 4'd3); rd(1, 5'd5);
    exp_rd("dp_no_see", 1, 1'b0, 32'h0, 4'h0);
    step(); idle(); rd(0, 5'd5);
    exp_rd("dp_vis", 0, 1'b1, 32'h0, 4'h3); exp_cnt("dp_cnt", 1);
    step(); idle(); cm(0, 5'd5, 32'hAA, 4'd3); rd(2, 5'd5);
    exp_rd("cm_byp", 2, 1'b0, 32'hAA, 4'h0); exp_cnt("cm_cnt_pre", 1);
    step(); idle(); rd(3, 5'd5);
    exp_rd("cm_store", 3, 1'b0, 32'hAA, 4'h0); exp_cnt("cm_cnt", 0);

    // stale commit
    step(); idle(); dp(5'd5, 4'd7);
    step(); idle(); cm(0, 5'd5, 32'h11, 4'd3); rd(0, 5'd5);
    exp_rd("stale_byp", 0, 1'b1, 32'h11, 4'h7);
    step(); idle(); rd(0, 5'd5);
    exp_rd("stale_store", 0, 1'b1, 32'h11, 4'h7); exp_cnt("stale_cnt", 1);

    // dual commit to one register, youngest wins
    step(); idle(); dp(5'd6, 4'd4);
    step(); idle(); cm(0, 5'd6, 32'h1, 4'd2); cm(1, 5'd6, 32'h2, 4'd4); rd(2, 5'd6);
    exp_rd("dual_byp", 2, 1'b0, 32'h2, 4'h0); exp_cnt("dual_cnt_pre", 2);
    step(); idle(); rd(2, 5'd6);
    exp_rd("dual_store", 2, 1'b0, 32'h2, 4'h0); exp_cnt("dual_cnt", 1);

    // dispatch collides with matching commit
    step(); idle(); dp(5'd7, 4'd1);
    step(); idle(); cm(0, 5'd7, 32'h77, 4'd1); dp(5'd7, 4'd5); rd(1, 5'd7);
    exp_rd("coll_byp", 1, 1'b0, 32'h77, 4'h0); exp_cnt("coll_cnt_pre", 2);
    step(); idle(); rd(1, 5'd7);
    exp_rd("coll_store", 1, 1'b1, 32'h77, 4'h5); exp_cnt("coll_cnt", 2);

    // flush with commit and ignored dispatch
    step(); idle(); dp(5'd3, 4'd9);
    step(); idle(); dp(5'd9, 4'd10);
    step(); idle(); in_flush_enable = 1'b1; cm(0, 5'd9, 32'h55, 4'd10); dp(5'd12, 4'd2);
    rd(0, 5'd9); rd(1, 5'd3);
    exp_rd("fl_nobyp", 0, 1'b1, 32'h0, 4'hA); exp_rd("fl_x3_pre", 1, 1'b1, 32'h0, 4'h9);
    exp_cnt("fl_cnt_pre", 4);
    step(); idle(); rd(0, 5'd9); rd(1, 5'd3); rd(2, 5'd12); rd(3, 5'd5);
    exp_rd("fl_x9", 0, 1'b0, 32'h55, 4'h0); exp_rd("fl_x3", 1, 1'b0, 32'h0, 4'h0);
    exp_rd("fl_dp_ign", 2, 1'b0, 32'h0, 4'h0); exp_rd("fl_x5", 3, 1'b0, 32'h11, 4'h0);
    exp_cnt("fl_cnt", 0);

    // x0 is hardwired
    step(); idle(); cm(1, 5'd0, 32'hFF, 4'd0); rd(3, 5'd0);
    exp_rd("x0_byp", 3, 1'b0, 32'h0, 4'h0);
    step(); idle(); rd(3, 5'd0);
    exp_rd("x0_store", 3, 1'b0, 32'h0, 4'h0); exp_cnt("x0_cnt", 0);

    // in_rdy low freezes state and disables bypass
    step(); idle(); in_rdy = 1'b0; cm(0, 5'd4, 32'h99, 4'd0); dp(5'd4, 4'd1); rd(0, 5'd4);
    exp_rd("rdy0_nobyp", 0, 1'b0, 32'h0, 4'h0);
    step(); idle(); rd(0, 5'd4);
    exp_rd("rdy0_store", 0, 1'b0, 32'h0, 4'h0); exp_cnt("rdy0_cnt", 0);

    // every register busy
    for (int r = 1; r < RN; r++) begin
      step(); idle(); dp(AW'(r), RW'(r % 16));
    end
    step(); idle(); rd(0, 5'd31); rd(1, 5'd7);
    exp_rd("full_x31", 0, 1'b1, 32'h0, 4'hF); exp_rd("full_x7", 1, 1'b1, 32'h77, 4'h7);
    exp_cnt("full_cnt", 31);
    step(); idle(); in_flush_enable = 1'b1;
    step(); idle(); exp_cnt("full_flush", 0);

    step(); idle();
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge in_clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file with per-register busy bit and ROB tag, the multi-port successor of the single-commit tagged register file. It sits between the decoder/dispatch stage and the ROB: `N_RD` read ports feed operand lookup, `N_CM` commit ports retire ROB entries in order each cycle, and one dispatch port renames a destination. New behaviour versus the single-port block:

- commit-to-read bypass;
- multi-commit with in-order priority;
- a registered busy-register count.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `REG_NUM`, 32, number of architectural registers, power of two; `REG_AW = $clog2(REG_NUM)`
- `ROB_W`, 4, ROB tag width; tag 0 is valid and reset value
- `N_RD`, 4, number of read ports
- `N_CM`, 2, number of commit ports; port 0 is oldest

Ports (port `i` of a flattened bus occupies slice `[i*W +: W]`):
- `in_clk`  in  1  clock, all state updates on rising edge
- `in_rst_n`  in  1  reset, asynchronous, active-low
- `in_rdy`  in  1  global enable; low freezes all state
- `in_flush_enable`  in  1  misprediction flush
- `in_dp_enable`  in  1  dispatch writes busy/tag for `in_dp_rd`
- `in_dp_rd`  in  `REG_AW`  dispatch destination register
- `in_dp_reorder`  in  `ROB_W`  dispatch ROB tag
- `in_rd_addr`  in  `N_RD*REG_AW`  read addresses
- `out_rd_busy`  out  `N_RD`  operand still pending
- `out_rd_data`  out  `N_RD*DATA_W`  operand value
- `out_rd_reorder`  out  `N_RD*ROB_W`  producing ROB tag
- `in_cm_enable`  in  `N_CM`  commit valid per port
- `in_cm_rd`  in  `N_CM*REG_AW`  commit destination
- `in_cm_value`  in  `N_CM*DATA_W`  commit value
- `in_cm_reorder`  in  `N_CM*ROB_W`  committing ROB tag
- `out_busy_cnt`  out  `REG_AW+1`  registered count of busy registers

## Operation
- **State.** Per register: `data[DATA_W]`, `busy`, and `tag[ROB_W]`.
- **Register x0.**
  - Reads return data 0, busy 0, tag 0.
  - Commits and dispatches targeting x0 are ignored entirely.
- **Read (combinational), port `i`, address `a`:**
  - Start from the stored `busy[a]`, `tag[a]` and `data[a]`.
  - **Bypass.** If some commit port `j` this cycle has `in_cm_enable[j]` and `in_cm_rd[j]==a != 0`, the youngest such `j` supplies `out_rd_data = in_cm_value[j]`.
  - In addition, if `busy[a]` and `tag[a]==in_cm_reorder[j]` for that `j`, then `out_rd_busy=0` and `out_rd_reorder=0`.
  - Bypass is qualified by `in_rdy` and is suppressed when `in_flush_enable=1`.
  - Reads never see a same-cycle dispatch, so an instruction reading its own destination gets the old mapping.
- **Commit update (`in_rdy=1`, no flush):**
  - Each enabled port with `rd != 0` writes `data[rd]`.
  - For the same `rd` on several ports, the highest index (youngest) wins.
  - `busy`/`tag` are cleared for `rd` when the stored tag equals that port's `in_cm_reorder`.
- **Dispatch update (`in_rdy=1`, no flush, `in_dp_enable`, `in_dp_rd != 0`):**
  - Sets `busy=1` and `tag=in_dp_reorder`.
  - Overrides any same-cycle commit clear of the same register; the commit's data write still happens.
- **Flush (`in_rdy=1`, `in_flush_enable=1`):**
  - All `busy` and `tag` are cleared.
  - Commit data writes are still performed on all enabled ports.
  - Dispatch is ignored.
- **`in_rdy=0`.** No state changes; read outputs stay live from stored state with no bypass.
- **`out_busy_cnt`.** Equals the number of registers whose busy bit is 1 after the edge. It is a registered value computed from the next-state busy vector, so it is exact for simultaneous set/clear on the same register.

## Timing
- **Reset.** Asynchronous assertion of `in_rst_n=0` immediately forces all `data`, `busy` and `tag` to 0 and `out_busy_cnt=0`. Consequently every read output is 0 during reset.
- **Reset release** is synchronous-safe: the first update occurs on the first rising edge with `in_rst_n=1`.
- **Reset mid-operation** discards any in-flight commit or dispatch of that cycle.
- **Latency.** Read is 0 cycles (combinational, including bypass). Commit and dispatch are visible in stored state 1 cycle later. `out_busy_cnt` reflects updates 1 cycle after the edge-causing inputs.
- There is no handshake: the ROB guarantees commit tags arrive oldest-first across ports, and dispatch guarantees tag uniqueness among in-flight entries.
- **Boundary.** With all `REG_NUM-1` registers busy, `out_busy_cnt=REG_NUM-1`; the counter width prevents overflow. Tag wrap-around needs no special handling because matching is by equality only.

## Test plan
- **Reset:** drive `in_rst_n` low mid-clock after writing x5=0x1234. Required: `out_rd_data` for x5 reads 0 before the next edge and `out_busy_cnt=0`.
- **Dispatch then commit:** dispatch x5 with tag 3; the next cycle shows busy=1, reorder=3, `out_busy_cnt=1`. Commit x5 with value 0xAA and tag 3: the same-cycle read shows busy=0, data 0xAA (bypass); the next cycle stores 0xAA, busy=0, count=0.
- **Stale commit:** x5 is busy with tag 7; commit x5 with tag 3 and value 0x11. Required: data=0x11, busy stays 1, tag stays 7.
- **Dual commit, same register:** port0 commits x6=0x1 with tag 2, port1 commits x6=0x2 with tag 4, stored tag 4. Required: data=0x2, busy cleared, bypass read returns 0x2.
- **Dispatch and commit collide:** commit x7 (tag 1 matching) while dispatching x7 with tag 5. Required: data updated, busy=1, tag=5, count unchanged.
- **Flush and x0:** with x3 and x9 busy, assert flush while committing x9=0x55. Required: all busy 0, count 0, x9=0x55, and dispatch ignored. Separately, commit x0=0xFF gives read x0 = 0 and not busy.
